// File: rtl/sopc_pkg.sv
// Shared types, default parameters and the address-to-slave helper used by the
// SOPC memory bus controller and its decoder.
package sopc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } bus_state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int N_SLV_DEF   = 4;
  localparam int SEL_W_DEF   = 2;
  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W       = 8;
  localparam int MAX_ADDR_W  = 64;

  // Top sel_w bits of an addr_w-wide address; the caller zero-extends to MAX_ADDR_W.
  function automatic logic [31:0] slv_index(input logic [MAX_ADDR_W-1:0] addr,
                                            input int addr_w, input int sel_w);
    return 32'(addr >> (addr_w - sel_w)) & ((32'd1 << sel_w) - 32'd1);
  endfunction

endpackage

// File: rtl/sopc_bus_decoder.sv
// Combinational address decoder: slave index, in-range flag and one-hot select.
module sopc_bus_decoder
  import sopc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_SLV  = N_SLV_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [SEL_W-1:0]  idx_o,
  output logic              valid_o,
  output logic [N_SLV-1:0]  onehot_o
);

  logic [31:0] idx_full;

  assign idx_full = slv_index(MAX_ADDR_W'(addr_i), ADDR_W, SEL_W);
  assign idx_o    = idx_full[SEL_W-1:0];
  assign valid_o  = idx_full < 32'(N_SLV);
  // Out-of-range indices must never select a slave.
  assign onehot_o = valid_o ? (N_SLV'(1) << idx_full) : '0;

endmodule

// File: rtl/sopc_bus_ctrl.sv
// Memory-bus controller between one OpenMIPS memory port and N_SLV slaves:
// address decode, req/ack handshake with timeout, pipeline stall and error report.
module sopc_bus_ctrl
  import sopc_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_SLV   = N_SLV_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_ce_i,
  input  logic                    m_we_i,
  input  logic [ADDR_W-1:0]       m_addr_i,
  input  logic [DATA_W/8-1:0]     m_sel_i,
  input  logic [DATA_W-1:0]       m_data_i,
  output logic [DATA_W-1:0]       m_data_o,
  output logic                    m_stall_o,
  output logic                    m_err_o,
  output logic [N_SLV-1:0]        s_cyc_o,
  output logic                    s_we_o,
  output logic [ADDR_W-1:0]       s_addr_o,
  output logic [DATA_W/8-1:0]     s_sel_o,
  output logic [DATA_W-1:0]       s_data_o,
  input  logic [N_SLV*DATA_W-1:0] s_data_i,
  input  logic [N_SLV-1:0]        s_ack_i
);

  bus_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic                  abort_q, abort_d;
  logic [N_SLV-1:0]      cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W/8-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [SEL_W-1:0]      dec_idx;
  logic                  dec_valid;
  logic [N_SLV-1:0]      dec_onehot;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic                  discard;

  sopc_bus_decoder #(
    .ADDR_W(ADDR_W),
    .N_SLV (N_SLV),
    .SEL_W (SEL_W)
  ) u_decoder (
    .addr_i  (m_addr_i),
    .idx_o   (dec_idx),
    .valid_o (dec_valid),
    .onehot_o(dec_onehot)
  );

  assign ack_hit     = s_ack_i[idx_q];
  assign timeout_hit = cnt_q == CNT_W'(TIMEOUT - 1);
  // A flushed access (ce dropped at any point in BUSY) finishes silently.
  assign discard     = abort_q | ~m_ce_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      abort_q <= 1'b0;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      abort_q <= abort_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (m_ce_i) state_d = dec_valid ? BUSY : ERR;
      BUSY: begin
        if (ack_hit || timeout_hit) begin
          if (discard)      state_d = IDLE;
          else if (ack_hit) state_d = DONE;
          else              state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state so they line up with it.
  always_comb begin
    cnt_d   = '0;
    idx_d   = idx_q;
    abort_d = 1'b0;
    cyc_d   = '0;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    err_d   = state_d == ERR;
    case (state_q)
      IDLE: begin
        if (state_d == BUSY) begin
          idx_d   = dec_idx;
          cyc_d   = dec_onehot;
          we_d    = m_we_i;
          addr_d  = m_addr_i;
          sel_d   = m_sel_i;
          wdata_d = m_data_i;
        end
      end
      BUSY: begin
        if (state_d == BUSY) begin
          cnt_d   = cnt_q + CNT_W'(1);
          cyc_d   = cyc_q;
          abort_d = abort_q | ~m_ce_i;
        end
      end
      default: ;
    endcase
    if (state_d == DONE && !we_q) rdata_d = s_data_i[idx_q*DATA_W +: DATA_W];
  end

  assign m_stall_o = rst & m_ce_i & ((state_q == IDLE) | (state_q == BUSY));
  assign m_data_o  = rdata_q;
  assign m_err_o   = err_q;
  assign s_cyc_o   = cyc_q;
  assign s_we_o    = we_q;
  assign s_addr_o  = addr_q;
  assign s_sel_o   = sel_q;
  assign s_data_o  = wdata_q;

endmodule

// File: tb/tb_sopc_bus_ctrl.sv
// Self-checking bench for sopc_bus_ctrl with three slaves and a short timeout:
// table-driven accesses checked through a result scoreboard, plus flush, reset and back-to-back sequences.
module tb_sopc_bus_ctrl;

  localparam int N  = 3;
  localparam int TO = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic [2:0]  strayAck;
    logic        expErr;
    logic [31:0] expData;
    int          expLat;
    logic [2:0]  expCyc;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mCe, mWe;
  logic [31:0]   mAddr, mDataIn, mDataOut, sAddr, sDataOut;
  logic [3:0]    mSel, sSel;
  logic          mStall, mErr, sWe;
  logic [N-1:0]  sCyc, sAck;
  logic [N*32-1:0] sData;

  int   nChecks = 0;
  int   nFail   = 0;
  exp_t sbQ[$];
  vec_t vecs[8];
  vec_t extra;

  sopc_bus_ctrl #(
    .ADDR_W(32), .DATA_W(32), .N_SLV(N), .SEL_W(2), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ce_i(mCe), .m_we_i(mWe), .m_addr_i(mAddr), .m_sel_i(mSel), .m_data_i(mDataIn),
    .m_data_o(mDataOut), .m_stall_o(mStall), .m_err_o(mErr),
    .s_cyc_o(sCyc), .s_we_o(sWe), .s_addr_o(sAddr), .s_sel_o(sSel), .s_data_o(sDataOut),
    .s_data_i(sData), .s_ack_i(sAck)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setSlaveData(input int slv, input logic [31:0] d);
    for (int i = 0; i < N; i++) sData[i*32 +: 32] = (i == slv) ? d : ~d;
  endtask

  // Each completed access (DONE or ERR with ce still high) retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst && mCe && !mStall) begin
      checkOutput("sb_nonempty", 64'(sbQ.size() != 0), 64'd1);
      if (sbQ.size() != 0) begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("result_err", 64'(mErr), 64'(e.err));
        checkOutput("result_data", 64'(mDataOut), 64'(e.data));
      end
    end
  end

  // Called at posedge+1 of the request cycle; returns at posedge+1 of the cycle after DONE/ERR
  // (plus one idle cycle when ce is released).
  task automatic applyStimulus(input vec_t v, input bit holdCe);
    int   slv;
    int   c;
    bit   fin;
    exp_t e;
    slv = int'(v.addr[31:30]);
    mCe = 1'b1; mWe = v.we; mAddr = v.addr; mSel = v.sel; mDataIn = v.wdata; sAck = '0;
    setSlaveData(slv, v.rdata);
    e.err = v.expErr; e.data = v.expData;
    sbQ.push_back(e);
    @(negedge clk);
    checkOutput("stall_req", 64'(mStall), 64'd1);
    checkOutput("cyc_req", 64'(sCyc), 64'd0);
    c = 0; fin = 1'b0;
    while (!fin && c < 20) begin
      c++;
      @(posedge clk); #1;
      sAck = '0;
      if (c - 1 == v.waits && slv < N) sAck[slv] = 1'b1;
      if (c == 1) sAck = sAck | v.strayAck;
      @(negedge clk);
      if (mStall) begin
        checkOutput("cyc_busy", 64'(sCyc), 64'(v.expCyc));
        checkOutput("we_busy", 64'(sWe), 64'(v.we));
        checkOutput("addr_busy", 64'(sAddr), 64'(v.addr));
        checkOutput("sel_busy", 64'(sSel), 64'(v.sel));
        checkOutput("wdata_busy", 64'(sDataOut), 64'(v.wdata));
      end else begin
        fin = 1'b1;
      end
    end
    checkOutput("latency", 64'(c), 64'(v.expLat));
    checkOutput("cyc_end", 64'(sCyc), 64'd0);
    @(posedge clk); #1;
    sAck = '0;
    if (!holdCe) begin
      mCe = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0] = '{we:1'b0, addr:32'h0000_0010, sel:4'hF, wdata:32'h0, waits:0, rdata:32'h2402_0001,
                strayAck:3'b000, expErr:1'b0, expData:32'h2402_0001, expLat:2, expCyc:3'b001};
    vecs[1] = '{we:1'b1, addr:32'h8000_0004, sel:4'b0011, wdata:32'hDEAD_BEEF, waits:3, rdata:32'h1111_2222,
                strayAck:3'b000, expErr:1'b0, expData:32'h0, expLat:5, expCyc:3'b100};
    vecs[2] = '{we:1'b0, addr:32'h4000_0100, sel:4'hF, wdata:32'h0, waits:2, rdata:32'h1234_5678,
                strayAck:3'b000, expErr:1'b0, expData:32'h1234_5678, expLat:4, expCyc:3'b010};
    vecs[3] = '{we:1'b0, addr:32'hC000_0000, sel:4'hF, wdata:32'h0, waits:99, rdata:32'h7777_7777,
                strayAck:3'b000, expErr:1'b1, expData:32'h0, expLat:1, expCyc:3'b000};
    vecs[4] = '{we:1'b0, addr:32'h0000_0020, sel:4'hF, wdata:32'h0, waits:99, rdata:32'h3C3C_3C3C,
                strayAck:3'b010, expErr:1'b1, expData:32'h0, expLat:5, expCyc:3'b001};
    vecs[5] = '{we:1'b0, addr:32'h8000_0008, sel:4'hF, wdata:32'h0, waits:1, rdata:32'hA5A5_0F0F,
                strayAck:3'b000, expErr:1'b0, expData:32'hA5A5_0F0F, expLat:3, expCyc:3'b100};
    vecs[6] = '{we:1'b1, addr:32'h4000_0044, sel:4'b1000, wdata:32'h0BAD_F00D, waits:0, rdata:32'h9999_8888,
                strayAck:3'b000, expErr:1'b0, expData:32'h0, expLat:2, expCyc:3'b010};
    vecs[7] = '{we:1'b0, addr:32'h0000_0004, sel:4'hF, wdata:32'h0, waits:3, rdata:32'hCAFE_F00D,
                strayAck:3'b100, expErr:1'b0, expData:32'hCAFE_F00D, expLat:5, expCyc:3'b001};

    rst = 1'b0; mCe = 1'b1; mWe = 1'b0; mAddr = 32'h0; mSel = 4'h0; mDataIn = 32'h0;
    sAck = '0; sData = '0;
    #12;
    $display("[TB] checking reset state");
    checkOutput("rst_stall", 64'(mStall), 64'd0);
    checkOutput("rst_cyc", 64'(sCyc), 64'd0);
    checkOutput("rst_err", 64'(mErr), 64'd0);
    checkOutput("rst_data", 64'(mDataOut), 64'd0);
    checkOutput("rst_saddr", 64'(sAddr), 64'd0);
    checkOutput("rst_swe", 64'(sWe), 64'd0);
    checkOutput("rst_ssel", 64'(sSel), 64'd0);
    checkOutput("rst_sdata", 64'(sDataOut), 64'd0);
    mCe = 1'b0;
    #8 rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] table-driven accesses");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 1'b0);

    $display("[TB] back-to-back accesses");
    applyStimulus(vecs[5], 1'b1);
    applyStimulus(vecs[0], 1'b0);

    $display("[TB] flush during BUSY");
    mCe = 1'b1; mWe = 1'b0; mAddr = 32'h0000_0030; mSel = 4'hF; sAck = '0;
    setSlaveData(0, 32'h5555_AAAA);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("flush_stall_c1", 64'(mStall), 64'd1);
    checkOutput("flush_cyc_c1", 64'(sCyc), 64'b001);
    @(posedge clk); #1; mCe = 1'b0;
    @(negedge clk);
    checkOutput("flush_stall_c2", 64'(mStall), 64'd0);
    checkOutput("flush_cyc_c2", 64'(sCyc), 64'b001);
    @(posedge clk); #1; sAck = 3'b001;
    @(negedge clk);
    checkOutput("flush_cyc_c3", 64'(sCyc), 64'b001);
    checkOutput("flush_err_c3", 64'(mErr), 64'd0);
    @(posedge clk); #1; sAck = '0;
    @(negedge clk);
    checkOutput("flush_cyc_c4", 64'(sCyc), 64'd0);
    checkOutput("flush_err_c4", 64'(mErr), 64'd0);
    checkOutput("flush_data_c4", 64'(mDataOut), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("flush_err_c5", 64'(mErr), 64'd0);
    checkOutput("flush_data_c5", 64'(mDataOut), 64'd0);
    @(posedge clk); #1;

    $display("[TB] reset during BUSY");
    mCe = 1'b1; mWe = 1'b1; mAddr = 32'h4000_0040; mSel = 4'hF; mDataIn = 32'h1357_9BDF;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstbusy_cyc_before", 64'(sCyc), 64'b010);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checkOutput("rstbusy_cyc", 64'(sCyc), 64'd0);
    checkOutput("rstbusy_stall", 64'(mStall), 64'd0);
    checkOutput("rstbusy_saddr", 64'(sAddr), 64'd0);
    checkOutput("rstbusy_swe", 64'(sWe), 64'd0);
    checkOutput("rstbusy_sdata", 64'(sDataOut), 64'd0);
    mCe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    extra = '{we:1'b0, addr:32'h8000_0080, sel:4'hF, wdata:32'h0, waits:1, rdata:32'h600D_CAFE,
              strayAck:3'b000, expErr:1'b0, expData:32'h600D_CAFE, expLat:3, expCyc:3'b100};
    applyStimulus(extra, 1'b0);

    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
